// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch FSM states and the
// default boot address, plus a small alignment helper.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    function automatic logic isWordAligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// IF/ID valid/ready handshake carrying the fetched word and its addresses
// from the fetch stage (master) to the decoder (slave).
interface ifetch_stage_if;
    import cpu_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus4;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        output out_pc_plus4,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4,
        output out_ready
    );

endinterface

// File: rtl/ifetch_stage_pc_reg.sv
// Program counter register: reset / redirect / sequential advance / hold,
// with a misalignment flag on the incoming redirect target.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_en_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_step_o,
    output logic              misaligned_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Unsigned add wraps modulo 2^32 with no carry out, as intended.
    assign pc_plus_step_o = pc_q + PC_STEP;
    assign misaligned_o   = !isWordAligned(redirect_pc_i);
    assign pc_o           = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_en_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_plus_step_o;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: drives IM.addr from the PC, registers IM.instr into
// the IF/ID slot under valid/ready, and halts on a misaligned redirect.
module ifetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic               clock,
    input  logic               reset,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    ifetch_stage_if.master     out_if,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pcPlusStep;
    logic               misaligned;

    logic               takeRedirect;
    logic               setFault;
    logic               capture;
    logic               transfer;

    logic               outValid_q,   outValid_d;
    logic [INSTR_W-1:0] outInstr_q,   outInstr_d;
    logic [ADDR_W-1:0]  outPc_q,      outPc_d;
    logic [ADDR_W-1:0]  outPcPlus4_q, outPcPlus4_d;
    logic               fault_q,      fault_d;
    logic [31:0]        fetchCount_q, fetchCount_d;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clock          (clock),
        .reset          (reset),
        .redirect_en_i  (takeRedirect),
        .redirect_pc_i  (redirect_pc),
        .advance_i      (capture),
        .pc_o           (pc),
        .pc_plus_step_o (pcPlusStep),
        .misaligned_o   (misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // BOOT always leaves after one cycle; only a bad redirect can reach FAULT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = (redirect_valid && misaligned) ? FAULT : RUN;
            RUN:     state_d = (redirect_valid && misaligned) ? FAULT : RUN;
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        takeRedirect = 1'b0;
        setFault     = 1'b0;
        capture      = 1'b0;
        unique case (state_q)
            BOOT: begin
                takeRedirect = redirect_valid;
                setFault     = redirect_valid && misaligned;
            end
            RUN: begin
                takeRedirect = redirect_valid;
                setFault     = redirect_valid && misaligned;
                capture      = !redirect_valid && (!outValid_q || out_if.out_ready);
            end
            default: begin
                takeRedirect = 1'b0;
                setFault     = 1'b0;
                capture      = 1'b0;
            end
        endcase
    end

    assign transfer = outValid_q && out_if.out_ready;

    // A transfer is counted even when a redirect flushes the slot that cycle.
    always_comb begin
        outValid_d   = outValid_q;
        outInstr_d   = outInstr_q;
        outPc_d      = outPc_q;
        outPcPlus4_d = outPcPlus4_q;
        fault_d      = fault_q || setFault;
        fetchCount_d = transfer ? fetchCount_q + 32'd1 : fetchCount_q;
        if (state_q == FAULT || takeRedirect) begin
            outValid_d = 1'b0;
        end else if (capture) begin
            outValid_d   = 1'b1;
            outInstr_d   = im_instr;
            outPc_d      = pc;
            outPcPlus4_d = pcPlusStep;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValid_q   <= 1'b0;
            outInstr_q   <= '0;
            outPc_q      <= '0;
            outPcPlus4_q <= '0;
            fault_q      <= 1'b0;
            fetchCount_q <= '0;
        end else begin
            outValid_q   <= outValid_d;
            outInstr_q   <= outInstr_d;
            outPc_q      <= outPc_d;
            outPcPlus4_q <= outPcPlus4_d;
            fault_q      <= fault_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign im_addr             = pc;
    assign out_if.out_valid    = outValid_q;
    assign out_if.out_instr    = outInstr_q;
    assign out_if.out_pc       = outPc_q;
    assign out_if.out_pc_plus4 = outPcPlus4_q;
    assign fault               = fault_q;
    assign fetch_count         = fetchCount_q;

endmodule
